// File: rtl/mm_iddmm_loader_pkg.sv
// mm_iddmm_pkg: state enum, default word geometry and address-width helper shared by mm_iddmm_loader and mm_iddmm_sp
package mm_iddmm_pkg;
  localparam int K_DEF = 128;
  localparam int N_DEF = 32;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, REST} state_t;
  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mm_iddmm_loader_if.sv
// mm_iddmm_loader_if: operand input stream, sp RAM/handshake side and result stream of the loader
interface mm_iddmm_loader_if import mm_iddmm_pkg::*; #(
  parameter int K  = K_DEF,
  parameter int AW = aw_of(N_DEF)
) ();
  logic          s_valid;
  logic          s_ready;
  logic [K-1:0]  s_x;
  logic [K-1:0]  s_y;
  logic [K-1:0]  s_m;
  logic [K-1:0]  s_m1;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_x;
  logic [K-1:0]  wr_y;
  logic [K-1:0]  wr_m;
  logic [K-1:0]  wr_m1;
  logic          task_req;
  logic          task_end;
  logic          res_val;
  logic [K-1:0]  res;
  logic          m_valid;
  logic [K-1:0]  m_data;
  logic          m_last;
  modport master (
    input  s_valid, s_x, s_y, s_m, s_m1, task_end, res_val, res,
    output s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req, m_valid, m_data, m_last
  );
  modport slave (
    output s_valid, s_x, s_y, s_m, s_m1, task_end, res_val, res,
    input  s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req, m_valid, m_data, m_last
  );
endinterface

// File: rtl/mm_iddmm_loader.sv
// mm_iddmm_loader: loads one Montgomery job into mm_iddmm_sp, runs task_req/task_end and forwards results.
// Optional MM_LOADER_TIMEOUT_EN aborts WAIT after TIMEOUT cycles without task_end.
module mm_iddmm_loader import mm_iddmm_pkg::*; #(
  parameter int K       = K_DEF,
  parameter int N       = N_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  mm_iddmm_loader_if.master bus,
  output logic              busy,
  output logic              err
);
  localparam int AW = aw_of(N);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [CW-1:0] NC   = CW'(N);
  localparam logic [CW-1:0] SAT  = CW'(N + 1);
  if (N < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("mm_iddmm_loader: requires N>=2 and TIMEOUT>=1");
  end
  state_t        r_state, w_nxt;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_rcnt, w_rcnt;
  logic          r_ready, r_busy, r_err, r_wr_ena, r_task_req, r_m_valid, r_m_last;
  logic [AW-1:0] r_wr_addr;
  logic [K-1:0]  r_wr_x, r_wr_y, r_wr_m, r_wr_m1, r_m_data;
  logic          w_acc, w_done, w_tmo;
  assign w_acc  = bus.s_valid & r_ready;
  assign w_done = r_state == WAIT && bus.task_end;
  // result count saturates at N+1 so an overrun stays distinguishable from exactly N
  assign w_rcnt = (bus.res_val && r_rcnt != SAT) ? r_rcnt + 1'b1 : r_rcnt;
`ifdef MM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tcnt <= '0;
    else        r_tcnt <= (r_state == WAIT) ? r_tcnt + 1'b1 : '0;
  assign w_tmo = r_state == WAIT && !bus.task_end && r_tcnt == TW'(TIMEOUT - 1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = w_acc ? LOAD : IDLE;
      LOAD:    w_nxt = (w_acc && r_addr == LAST) ? START : LOAD;
      START:   w_nxt = WAIT;
      WAIT:    w_nxt = (w_done || w_tmo) ? REST : WAIT;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rcnt     <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_ena   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_m     <= '0;
      r_wr_m1    <= '0;
      r_task_req <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ready    <= w_nxt == IDLE || w_nxt == LOAD;
      r_busy     <= w_nxt != IDLE;
      r_task_req <= w_nxt == WAIT;
      r_wr_ena   <= w_acc;
      if (w_acc) begin
        r_wr_addr <= r_addr;
        r_wr_x    <= bus.s_x;
        r_wr_y    <= bus.s_y;
        r_wr_m    <= bus.s_m;
        r_addr    <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
      end
      if (w_acc && r_state == IDLE) begin
        r_wr_m1 <= bus.s_m1;
        r_err   <= 1'b0;
      end
      if (r_state == START) r_rcnt <= '0;
      if (r_state == WAIT) r_rcnt <= w_rcnt;
      r_m_valid <= r_state == WAIT && bus.res_val;
      r_m_last  <= r_state == WAIT && bus.res_val && w_rcnt == NC;
      if (r_state == WAIT && bus.res_val) r_m_data <= bus.res;
      if ((w_done && w_rcnt != NC) || w_tmo) r_err <= 1'b1;
    end
  assign bus.s_ready  = r_ready;
  assign bus.wr_ena   = r_wr_ena;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_x     = r_wr_x;
  assign bus.wr_y     = r_wr_y;
  assign bus.wr_m     = r_wr_m;
  assign bus.wr_m1    = r_wr_m1;
  assign bus.task_req = r_task_req;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_data   = r_m_data;
  assign bus.m_last   = r_m_last;
  assign busy         = r_busy;
  assign err          = r_err;
endmodule
